iot_feeder: RTL and testbench
=============================

# iot_feeder

Byte-stream transmitter for the IoT data-filter (IOTDF) input port. It accepts 128-bit sensor words from an upstream producer over a valid/ready handshake and buffers them in a 2-entry FIFO. It serialises each word MSB-byte first onto `iot_in`/`in_en`, one byte per cycle, stalling whenever the filter raises `busy`. It is the synthesizable counterpart of the filter's receive side and replaces bench-driven byte injection in the integrated design.

## Interface
- `WORD_W`, 128: word width; fixed at 16 × `BYTE_W`.
- `BYTE_W`, 8: serial byte width.
- `CNT_W`, 8: width of `word_cnt`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  upstream word valid.
- `wr_data`  in  WORD_W  upstream word.
- `wr_ready`  out  1  FIFO not full.
- `busy`  in  1  filter busy; sampled at every rising edge.
- `in_en`  out  1  byte valid to the filter; registered.
- `iot_in`  out  BYTE_W  byte to the filter; registered.
- `word_done`  out  1  one-cycle pulse, coincident with the byte-15 beat.
- `word_cnt`  out  CNT_W  count of fully sent words; wraps modulo 2^CNT_W.
- `idle`  out  1  FIFO empty and no word in progress.

## Operation
- **FIFO.** 2 entries with head/tail pointers and a 2-bit occupancy count.
  - `wr_ready` = (count < 2).
  - Push on `wr_valid && wr_ready`.
  - `wr_valid` while full is ignored; upstream must hold the word.
- **Byte index.** `idx` runs 0..15 over the head word.
  - The byte sent is `head[127-8*idx -: 8]`, so byte 0 is bits [127:120].
- **FSM states.**
  - IDLE: FIFO empty.
  - SEND: head present, `busy` low.
  - HOLD: head present, `busy` high.
- **Each rising edge, `busy` low and FIFO non-empty (SEND):**
  - `in_en`←1, `iot_in`←current byte, `idx`←`idx`+1.
  - If `idx` was 15: pop head, `idx`←0, `word_done`←1, `word_cnt`++.
- **Each rising edge, `busy` high or FIFO empty (HOLD/IDLE):**
  - `in_en`←0, `iot_in`←0, `word_done`←0.
  - `idx` holds. The byte is re-presented in full once `busy` falls; no byte is skipped or duplicated.
- **Transitions.**
  - IDLE→SEND on non-empty with `busy` low; IDLE→HOLD on non-empty with `busy` high.
  - SEND↔HOLD follows `busy`.
  - SEND→IDLE when the last byte of the last buffered word is issued.
- **Simultaneous push and pop** on the same edge: count unchanged, both pointers advance. A push at count 2 cannot occur because `wr_ready` is low.
- **Back-to-back words.** If the next word is already buffered, its byte 0 follows byte 15 of the previous word on the next cycle with no bubble.
- `idle` = (count == 0). `idx` is always 0 when count is 0.
- **Reset, including mid-word.** `rst` low clears the FIFO, pointers, `idx` and `word_cnt`. Any partially sent word is discarded and is not resumed.

## Timing
- **Reset values:** `in_en`=0, `iot_in`=0, `word_done`=0, `word_cnt`=0, `wr_ready`=1, `idle`=1.
- **Accept to first byte:** a word accepted at edge N drives `in_en`=1 after edge N+1, provided `busy` is low at N+1.
- **Throughput:** 16 cycles per word when `busy` stays low; sustained one byte per cycle.
- **`busy` response:** `busy` sampled high at edge M forces `in_en`=0 after edge M, one-cycle response. The filter must tolerate at most that one in-flight byte registered at edge M-1.
- **`wr_ready`:** deasserts the cycle after the second entry is filled. It reasserts after the edge that issues byte 15 of the head word.
- **`word_cnt`:** increments on the same edge that raises `word_done`; 255+1→0.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `wr_valid`=1 → all outputs at their reset values; nothing accepted; `word_cnt`=0.
- **Single word:** push 0x00112233_44556677_8899AABB_CCDDEEFF with `busy`=0 → 16 consecutive beats 00,11,…,FF; first beat 1 cycle after accept; `word_done` on the FF beat; `word_cnt`=1; `idle`=1 afterwards.
- **Stall:** same word, `busy`=1 for 3 edges starting at the edge that would issue byte 5 → beats 00..44, then 3 cycles of `in_en`=0/`iot_in`=0, then 55..FF; exactly 16 beats in total.
- **Back-to-back:** push words A, B, C on consecutive cycles → `wr_ready` low after A and B are buffered; C accepted after A's byte 15; 48 contiguous beats; `word_cnt`=3.
- **Reset mid-word:** pulse `rst` low after byte 7 of word A → outputs return to reset values; a new word D then sends its bytes 0..15 with nothing from A.
- **Wrap and simultaneous events:** send 256 words with random `busy` → `word_cnt` wraps to 0; a push and a pop on the same edge leave the count unchanged.

Source files
------------

// File: rtl/iot_feeder.sv
// iot_feeder: buffers 128-bit sensor words in a 2-entry FIFO and streams
// them MSB-byte first to the IOTDF input port, pausing while busy is high.
module iot_feeder #(
  parameter int WORD_W = 128,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              busy,
  output logic              in_en,
  output logic [BYTE_W-1:0] iot_in,
  output logic              word_done,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              idle
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t state_q, state_d;

  logic [1:0][WORD_W-1:0]       mem;
  logic [NBYTES-1:0][BYTE_W-1:0] head_bytes;
  logic                         hp, tp;
  logic [1:0]                   cnt;
  logic [IDX_W-1:0]             idx;
  logic                         push, pop, last;
  logic [BYTE_W-1:0]            cur_byte, iot_q;
  logic                         done_q;
  logic [CNT_W-1:0]             wcnt_q;

  assign wr_ready  = (cnt < 2'd2);
  assign idle      = (cnt == 2'd0);
  assign last      = (idx == LAST_IDX);
  assign push      = wr_valid && wr_ready;
  assign pop       = (state_d == SEND) && last;

  // Packed view of the head word: element NBYTES-1 holds bits [127:120],
  // so byte index 0 maps to the top element.
  assign head_bytes = mem[hp];
  assign cur_byte   = head_bytes[LAST_IDX - idx];

  // in_en is decoded straight from the registered state, so it stays a flop output.
  assign in_en     = (state_q == SEND);
  assign iot_in    = iot_q;
  assign word_done = done_q;
  assign word_cnt  = wcnt_q;

  // Classify this cycle: nothing buffered, stalled by the filter, or sending.
  always_comb begin
    state_d = IDLE;
    if (cnt != 2'd0) state_d = busy ? HOLD : SEND;
  end

  // State register: records what the last edge did.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FIFO storage; stale contents are harmless because pointers gate them.
  always_ff @(posedge clk) begin
    if (push) mem[tp] <= wr_data;
  end

  // FIFO pointers/occupancy, byte index and the registered byte outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp     <= 1'b0;
      tp     <= 1'b0;
      cnt    <= 2'd0;
      idx    <= '0;
      iot_q  <= '0;
      done_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      if (push) tp <= ~tp;
      if (pop)  hp <= ~hp;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (state_d == SEND) begin
        iot_q  <= cur_byte;
        done_q <= last;
        idx    <= last ? '0 : idx + 1'b1;
        if (last) wcnt_q <= wcnt_q + 1'b1;
      end else begin
        // Stalled or empty: idx holds so the pending byte is re-sent intact.
        iot_q  <= '0;
        done_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iot_feeder.sv
// Directed bench for iot_feeder: reset, single word, stall, back-to-back
// with simultaneous push/pop, mid-word reset, and word counter wrap.
module tb_iot_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid;
  logic [127:0] wr_data;
  logic         wr_ready;
  logic         busy;
  logic         in_en;
  logic [7:0]   iot_in;
  logic         word_done;
  logic [7:0]   word_cnt;
  logic         idle;

  int checks = 0;
  int errors = 0;

  iot_feeder #(.WORD_W(128), .BYTE_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .in_en(in_en), .iot_in(iot_in),
    .word_done(word_done), .word_cnt(word_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs settle 1 time unit after the edge; inputs are also driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] WA = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] WB = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] WC = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] WD = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;

  initial begin
    logic [127:0] cur;
    logic [7:0]   expq [$];
    logic [7:0]   eb;
    logic         acc, bz;
    int           pushed, beats, bad, dn, nb, g, w, b;

    // ---- reset held with wr_valid asserted ----
    rst = 1'b0; wr_valid = 1'b1; wr_data = W1; busy = 1'b0;
    step(); step();
    chk("rst_in_en", in_en, 1'b0);
    chk("rst_iot_in", iot_in, 8'h00);
    chk("rst_word_done", word_done, 1'b0);
    chk("rst_word_cnt", word_cnt, 8'd0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_idle", idle, 1'b1);
    wr_valid = 1'b0; rst = 1'b1;
    step();
    chk("rst_nothing_accepted", {idle, in_en}, 2'b10);

    // ---- single word, busy low ----
    wr_valid = 1'b1; wr_data = W1;
    step();
    wr_valid = 1'b0;
    chk("single_no_beat_at_accept", {in_en, idle}, 2'b00);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("single_beat%0d", i), {in_en, iot_in, word_done}, {1'b1, 8'(i * 17), i == 15});
    end
    chk("single_word_cnt", word_cnt, 8'd1);
    step();
    chk("single_after", {in_en, iot_in, idle}, {1'b0, 8'h00, 1'b1});

    // ---- stall: busy high for the 3 edges that would issue byte 5 onward ----
    wr_valid = 1'b1; wr_data = W1;
    step();
    wr_valid = 1'b0;
    nb = 0;
    for (int e = 1; e <= 19; e++) begin
      busy = (e >= 6 && e <= 8);
      step();
      if (in_en) nb++;
      if (e >= 6 && e <= 8) begin
        chk($sformatf("stall_hold%0d", e), {in_en, iot_in, word_done}, 10'd0);
      end else begin
        b = (e <= 5) ? e - 1 : e - 4;
        chk($sformatf("stall_beat%0d", b), {in_en, iot_in, word_done}, {1'b1, 8'(b * 17), b == 15});
      end
    end
    busy = 1'b0;
    chk("stall_beat_total", nb, 16);
    chk("stall_word_cnt", word_cnt, 8'd2);

    // ---- back-to-back A,B,C, then D pushed on C's last-byte edge ----
    for (int e = 1; e <= 65; e++) begin
      wr_valid = 1'b1;
      if (e == 1)                 wr_data = WA;
      else if (e == 2)            wr_data = WB;
      else if (e >= 3 && e <= 18) wr_data = WC;
      else if (e == 49)           wr_data = WD;
      else                        wr_valid = 1'b0;
      step();
      if (e == 1) begin
        chk("b2b_first_no_beat", in_en, 1'b0);
      end else begin
        g = e - 2; w = g / 16; b = g % 16;
        eb = {4'(10 + w), 4'(b)};
        chk($sformatf("b2b_beat%0d", g), {in_en, iot_in, word_done}, {1'b1, eb, b == 15});
      end
      chk($sformatf("b2b_wr_ready_e%0d", e), wr_ready,
          !((e >= 2 && e <= 16) || (e >= 18 && e <= 32)));
      if (e == 49) chk("b2b_push_pop_idle", idle, 1'b0);
    end
    wr_valid = 1'b0;
    chk("b2b_word_cnt", word_cnt, 8'd6);
    step();
    chk("b2b_idle_after", {idle, in_en}, 2'b10);

    // ---- reset mid-word ----
    wr_valid = 1'b1; wr_data = WA;
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid_before_rst", {in_en, iot_in}, {1'b1, 8'hA7});
    rst = 1'b0;
    #2;
    chk("mid_rst_in_en", in_en, 1'b0);
    chk("mid_rst_iot_in", iot_in, 8'h00);
    chk("mid_rst_word_done", word_done, 1'b0);
    chk("mid_rst_word_cnt", word_cnt, 8'd0);
    chk("mid_rst_wr_ready", wr_ready, 1'b1);
    chk("mid_rst_idle", idle, 1'b1);
    #2;
    rst = 1'b1;
    wr_valid = 1'b1; wr_data = WD;
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("mid_d_beat%0d", i), {in_en, iot_in, word_done}, {1'b1, 8'hD0 + 8'(i), i == 15});
    end
    chk("mid_word_cnt", word_cnt, 8'd1);
    step();
    chk("mid_idle_after", {idle, in_en}, 2'b10);

    // ---- 255 more words with random busy: counter wraps to 0 ----
    pushed = 0; beats = 0; bad = 0; dn = 0;
    cur = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 12000 && beats < 4080; c++) begin
      bz = ($urandom_range(3) == 0);
      busy = bz;
      wr_valid = (pushed < 255);
      wr_data = cur;
      acc = wr_valid && wr_ready;
      step();
      if (acc) begin
        for (int k = 0; k < 16; k++) expq.push_back(cur[127 - 8 * k -: 8]);
        pushed++;
        cur = {$urandom, $urandom, $urandom, $urandom};
      end
      if (in_en) begin
        if (expq.size() == 0 || iot_in !== expq[0]) bad++;
        if (expq.size() != 0) void'(expq.pop_front());
        if (bz) bad++;
        if (word_done !== (beats % 16 == 15)) bad++;
        if (word_done) dn++;
        beats++;
      end else if (word_done || iot_in !== 8'h00) begin
        bad++;
      end
    end
    busy = 1'b0; wr_valid = 1'b0;
    chk("wrap_beats", beats, 4080);
    chk("wrap_bad_beats", bad, 0);
    chk("wrap_done_pulses", dn, 255);
    chk("wrap_word_cnt", word_cnt, 8'd0);
    step();
    chk("wrap_idle_after", {idle, in_en, wr_ready}, 3'b101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
